// File: rtl/rr_merge_type.sv
// Round-robin N-to-1 merge with a separate winner-index channel.
// Data and index complete independently; the grant stays locked until both have.
module rr_merge_type #(
    parameter int SIZE       = 2,
    parameter int DATA_TYPE  = 32,
    parameter int INDEX_TYPE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SIZE*DATA_TYPE-1:0] ins,
    input  logic [SIZE-1:0]           ins_valid,
    output logic [SIZE-1:0]           ins_ready,
    output logic [DATA_TYPE-1:0]      outs,
    output logic                      outs_valid,
    input  logic                      outs_ready,
    output logic [INDEX_TYPE-1:0]     index,
    output logic                      index_valid,
    input  logic                      index_ready
);

    logic [INDEX_TYPE-1:0] rr_ptr;
    logic [INDEX_TYPE-1:0] lock_idx;
    logic [INDEX_TYPE-1:0] sel;
    logic [INDEX_TYPE-1:0] nxt_ptr;
    logic                  lock;
    logic                  sent_data;
    logic                  sent_index;
    logic                  any;
    logic                  done_d;
    logic                  done_i;
    logic                  fire;
    logic                  found;
    int                    j;

    // Scan from rr_ptr with wrap; a locked grant overrides the scan.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        j     = 0;
        if (lock) begin
            sel = lock_idx;
        end else begin
            for (int k = 0; k < SIZE; k++) begin
                j = int'(rr_ptr) + k;
                if (j >= SIZE) j = j - SIZE;
                if (!found && ins_valid[j]) begin
                    sel   = INDEX_TYPE'(j);
                    found = 1'b1;
                end
            end
        end
    end

    assign any         = ~rst & ins_valid[sel];
    assign outs        = ins[int'(sel)*DATA_TYPE +: DATA_TYPE];
    assign index       = sel;
    assign outs_valid  = any & ~sent_data;
    assign index_valid = any & ~sent_index;
    assign done_d      = sent_data | (outs_valid & outs_ready);
    assign done_i      = sent_index | (index_valid & index_ready);
    assign fire        = any & done_d & done_i;
    assign nxt_ptr     = (int'(sel) == SIZE - 1) ? '0 : sel + INDEX_TYPE'(1);

    always_comb begin
        ins_ready      = '0;
        ins_ready[sel] = fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            lock_idx   <= '0;
            sent_data  <= 1'b0;
            sent_index <= 1'b0;
        end else if (fire) begin
            rr_ptr     <= nxt_ptr;
            lock       <= 1'b0;
            sent_data  <= 1'b0;
            sent_index <= 1'b0;
        end else if (any) begin
            lock       <= 1'b1;
            lock_idx   <= sel;
            sent_data  <= done_d;
            sent_index <= done_i;
        end
    end

endmodule

// File: tb/tb_rr_merge_type.sv
// Directed and randomized checks of rr_merge_type (SIZE=4 and SIZE=2).
// Random traffic is scored against a round-robin token model.
module tb_rr_merge_type;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [127:0] ins4 = '0;
    logic [3:0]   v4 = '0;
    logic [3:0]   rdy4;
    logic [31:0]  outs4;
    logic         ov4;
    logic         or4 = 1'b0;
    logic [1:0]   idx4;
    logic         iv4;
    logic         ir4 = 1'b0;

    logic [63:0]  ins2 = '0;
    logic [1:0]   v2 = '0;
    logic [1:0]   rdy2;
    logic [31:0]  outs2;
    logic         ov2;
    logic         or2 = 1'b0;
    logic [0:0]   idx2;
    logic         iv2;
    logic         ir2 = 1'b0;

    int n_asserts = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_merge_type #(.SIZE(4), .DATA_TYPE(32), .INDEX_TYPE(2)) dut4 (
        .clk(clk), .rst(rst), .ins(ins4), .ins_valid(v4), .ins_ready(rdy4),
        .outs(outs4), .outs_valid(ov4), .outs_ready(or4),
        .index(idx4), .index_valid(iv4), .index_ready(ir4)
    );

    rr_merge_type #(.SIZE(2), .DATA_TYPE(32), .INDEX_TYPE(1)) dut2 (
        .clk(clk), .rst(rst), .ins(ins2), .ins_valid(v2), .ins_ready(rdy2),
        .outs(outs2), .outs_valid(ov2), .outs_ready(or2),
        .index(idx2), .index_valid(iv2), .index_ready(ir2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // random-phase model state
    int  seq[4];
    bit  have[4];
    int  issued = 0;
    int  exp_fire = 0, exp_rd = 0, exp_ri = 0;
    int  got_fire = 0, got_rd = 0, got_ri = 0;
    bit  busy = 0, gd = 0, gi = 0;
    int  owner = 0, nxtp = 0;
    int  es, jj;
    bit  ea, eov, eiv, dd, di, ef;

    initial begin
        // reset holds everything quiet even with requests pending
        v4 = 4'hF; or4 = 1; ir4 = 1;
        v2 = 2'b11; or2 = 1; ir2 = 1;
        @(negedge clk); #1;
        chk("rst_ins_ready4", rdy4, 4'b0);
        chk("rst_outs_valid4", ov4, 0);
        chk("rst_index_valid4", iv4, 0);
        chk("rst_ins_ready2", rdy2, 2'b0);
        @(negedge clk);
        rst = 0; v4 = 0; v2 = 0;
        for (int i = 0; i < 4; i++) ins4[i*32 +: 32] = 32'h1000 + i;

        // constant contention: strict rotation, one grant per cycle
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            v4 = 4'hF; or4 = 1; ir4 = 1;
            #1;
            chk("rot_index", idx4, c % 4);
            chk("rot_outs", outs4, 32'h1000 + (c % 4));
            chk("rot_ins_ready", rdy4, 4'b1 << (c % 4));
        end

        // lone request on input 2 fires same cycle, pointer moves to 3
        @(negedge clk);
        v4 = 4'b0100; ins4[64 +: 32] = 32'hAB;
        #1;
        chk("single_outs", outs4, 32'hAB);
        chk("single_index", idx4, 2);
        chk("single_ready", rdy4, 4'b0100);
        @(negedge clk);
        v4 = 4'hF;
        #1;
        chk("after_single_index", idx4, 3);
        @(negedge clk);
        v4 = 4'hF;
        #1;
        chk("wrap_index", idx4, 0);
        @(negedge clk);
        v4 = 0;

        // SIZE=2: data accepted early, index held back three cycles
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            v2 = 2'b11; or2 = 1; ir2 = (c == 3);
            #1;
            chk("split_outs_valid", ov2, c == 0);
            chk("split_index_valid", iv2, 1);
            chk("split_index", idx2, 0);
            chk("split_ins_ready", rdy2, (c == 3) ? 2'b01 : 2'b00);
        end

        // lock on input 1; later request from input 0 must wait
        @(negedge clk);
        v2 = 2'b10; or2 = 1; ir2 = 0;
        #1;
        chk("lock_index", idx2, 1);
        chk("lock_outs_valid", ov2, 1);
        chk("lock_ins_ready", rdy2, 2'b00);
        @(negedge clk);
        v2 = 2'b11;
        #1;
        chk("lock_hold_index", idx2, 1);
        chk("lock_hold_outs_valid", ov2, 0);
        chk("lock_hold_ready", rdy2, 2'b00);
        @(negedge clk);
        ir2 = 1;
        #1;
        chk("lock_fire_ready", rdy2, 2'b10);
        @(negedge clk);
        v2 = 2'b11;
        #1;
        chk("lock_next_index", idx2, 0);
        chk("lock_next_ready", rdy2, 2'b01);

        // reset in the middle of a partial transfer
        @(negedge clk);
        v2 = 2'b11; or2 = 1; ir2 = 0;
        #1;
        chk("mid_pre_index", idx2, 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_ready", rdy2, 2'b00);
        chk("mid_rst_ov", ov2, 0);
        chk("mid_rst_iv", iv2, 0);
        @(negedge clk);
        rst = 0; ir2 = 1;
        #1;
        chk("mid_after_ov", ov2, 1);
        chk("mid_after_index", idx2, 0);
        chk("mid_after_ready", rdy2, 2'b01);
        @(negedge clk);
        v2 = 0; or2 = 0; ir2 = 0;
        v4 = 0; or4 = 0; ir4 = 0;

        // random elastic traffic on SIZE=4 against the token model
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            have[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!have[i] && $urandom_range(1, 0) == 1) begin
                    have[i] = 1;
                    seq[i]++;
                    issued++;
                end
                v4[i] = have[i];
                ins4[i*32 +: 32] = {8'(i), 24'(seq[i])};
            end
            or4 = $urandom_range(3, 0) != 0;
            ir4 = $urandom_range(3, 0) != 0;
            #1;
            ea = 0;
            es = nxtp;
            if (busy) begin
                es = owner;
                ea = have[owner];
            end else begin
                for (int k = 0; k < 4; k++) begin
                    jj = (nxtp + k) % 4;
                    if (!ea && have[jj]) begin
                        es = jj;
                        ea = 1;
                    end
                end
            end
            eov = ea && !gd;
            eiv = ea && !gi;
            dd = gd || (eov && or4);
            di = gi || (eiv && ir4);
            ef = ea && dd && di;
            chk("rand_outs_valid", ov4, eov);
            chk("rand_index_valid", iv4, eiv);
            chk("rand_ins_ready", rdy4, ef ? (4'b1 << es) : 4'b0);
            if (eov) chk("rand_outs", outs4, {8'(es), 24'(seq[es])});
            if (eiv) chk("rand_index", idx4, es);
            if (ov4 && or4) got_rd++;
            if (iv4 && ir4) got_ri++;
            if (|rdy4) got_fire++;
            if (eov && or4) exp_rd++;
            if (eiv && ir4) exp_ri++;
            if (ef) begin
                exp_fire++;
                have[es] = 0;
                busy = 0;
                gd = 0;
                gi = 0;
                nxtp = (es + 1) % 4;
            end else if (ea) begin
                busy = 1;
                owner = es;
                gd = dd;
                gi = di;
            end
        end
        @(negedge clk);
        v4 = 0;
        chk("rand_data_count", got_rd, exp_rd);
        chk("rand_index_count", got_ri, exp_ri);
        chk("rand_fire_count", got_fire, exp_fire);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
